credit_drain_buffer: RTL

Receive-side buffer at the tail of a fixed-latency, non-stallable datapath pipeline: it accepts the pipeline's output beats, presents them downstream over a valid/ready handshake, and returns credits to the pipeline's issue point so back-pressure never requires stalling the pipeline itself. It sits between the last delay stage of a compute lane and the lane's result consumer (writeback or next accelerator stage). It guarantees that every issued beat has a slot reserved before it enters the pipeline.

---
 rtl/credit_drain_buffer_pkg.sv | 34 +++
 rtl/credit_drain_buffer_if.sv | 45 ++++
 rtl/credit_drain_buffer_mem.sv | 34 +++
 rtl/credit_drain_buffer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/credit_drain_buffer_pkg.sv
// credit_drain_buffer_pkg
//   Shared definitions for credit-managed lane buffers: default payload width,
//   buffer depth and pipeline latency, the counter-width helper, and an
//   elaboration-time check that the buffer depth covers the pipeline latency.
//   No ports.

`ifndef CREDIT_DRAIN_BUFFER_PKG_SV
`define CREDIT_DRAIN_BUFFER_PKG_SV

// Elaboration check for a credit-managed buffer.
// Instantiate it inside a module body, after the parameters are declared.
// Elaboration fails when any of these holds:
//   - D is less than L + 2
//   - D is less than 2
//   - D is not a power of two
`define CDB_CHECK_DEPTH(D, L) \
  if (((D) < (L) + 2) || ((D) < 2) || (((D) & ((D) - 1)) != 0)) begin : g_cdb_depth_check \
    $error("credit buffer: DEPTH must be a power of two >= 2 and >= LATENCY+2"); \
  end

package credit_drain_buffer_pkg;

  localparam int unsigned CDB_WIDTH_DEFAULT   = 32;
  localparam int unsigned CDB_DEPTH_DEFAULT   = 32;
  localparam int unsigned CDB_LATENCY_DEFAULT = 16;

  // Width of a counter that has to hold every value from 0 to depth inclusive.
  function automatic int unsigned cdb_count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`endif

// File: rtl/credit_drain_buffer_if.sv
// credit_drain_buffer_if
//   Bundles the signals of one lane's receive buffer.
//   master modport: the upstream issue point together with the downstream
//   consumer. It drives the following signals:
//     - issue
//     - in_valid
//     - in_data
//     - out_ready
//   slave modport: the buffer itself. It drives the following signals:
//     - issue_ok
//     - out_valid
//     - out_data
//     - occupancy
//     - inflight
//     - err

interface credit_drain_buffer_if
  import credit_drain_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = CDB_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = CDB_DEPTH_DEFAULT
);
  localparam int unsigned CW = cdb_count_width(DEPTH);

  logic             issue;
  logic             issue_ok;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;
  logic [CW-1:0]    inflight;
  logic             err;

  modport master (
    output issue, in_valid, in_data, out_ready,
    input  issue_ok, out_valid, out_data, occupancy, inflight, err
  );

  modport slave (
    input  issue, in_valid, in_data, out_ready,
    output issue_ok, out_valid, out_data, occupancy, inflight, err
  );
endinterface

// File: rtl/credit_drain_buffer_mem.sv
// credit_drain_mem
//   Register-array simple dual-port memory.
//   There is one synchronous write port and one combinational read port.
//   The storage is never reset.
//   Ports:
//     - clk     : clock
//     - we_i    : write enable
//     - waddr_i : write address
//     - wdata_i : write data
//     - raddr_i : read address
//     - rdata_o : read data, mem[raddr_i]

module credit_drain_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/credit_drain_buffer.sv
// credit_drain_buffer
//   Receive buffer at the tail of a fixed-latency, non-stallable pipeline.
//   It stores arriving beats in a circular buffer and presents them downstream
//   over a valid/ready handshake.
//   It grants issue credits only while buffered beats plus in-flight beats are
//   fewer than DEPTH. Every beat that enters the pipeline therefore has a slot
//   reserved before it arrives.
//   Ports:
//     - clk : clock
//     - rst : synchronous reset, active-high
//     - bus : credit_drain_buffer_if.slave. It carries the following signals:
//       - issue and issue_ok
//       - in_valid and in_data
//       - out_valid, out_data and out_ready
//       - occupancy and inflight
//       - err

module credit_drain_buffer
  import credit_drain_buffer_pkg::*;
#(
  parameter int unsigned WIDTH   = CDB_WIDTH_DEFAULT,
  parameter int unsigned DEPTH   = CDB_DEPTH_DEFAULT,
  parameter int unsigned LATENCY = CDB_LATENCY_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  credit_drain_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cdb_count_width(DEPTH);

  `CDB_CHECK_DEPTH(DEPTH, LATENCY)

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          err_q, err_d;

  logic          issue_ok;
  logic [CW:0]   credit_sum;
  logic          empty, full;
  logic          issue_acc, arrive, push, pop, violation;

  // The credit decision depends only on registered counters.
  // No input ever reaches issue_ok combinationally.
  assign credit_sum = (CW+1)'(occ_q) + (CW+1)'(infl_q);
  assign issue_ok   = credit_sum < (CW+1)'(DEPTH);

  assign empty = (occ_q == '0);
  assign full  = (occ_q == CW'(DEPTH));

  always_comb begin
    issue_acc = bus.issue & issue_ok;
    arrive    = bus.in_valid & (infl_q != '0);
    pop       = ~empty & bus.out_ready;
    // When the buffer is full, a beat is accepted only if the head leaves in
    // the same cycle and frees its slot.
    push      = arrive & (~full | pop);

    violation = (bus.issue & ~issue_ok)
              | (bus.in_valid & (infl_q == '0))
              | (bus.in_valid & full & ~pop);
    err_d     = err_q | violation;

    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    // Any arrival while beats are outstanding retires one in-flight beat.
    // This holds even when the beat itself is dropped at a full buffer.
    infl_d = infl_q;
    unique case ({issue_acc, arrive})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  credit_drain_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.out_data)
  );

  assign bus.issue_ok  = issue_ok;
  assign bus.out_valid = ~empty;
  assign bus.occupancy = occ_q;
  assign bus.inflight  = infl_q;
  assign bus.err       = err_q;
endmodule
